// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared widths, FSM encoding, response entry type and parity
//               helper for the parity-protected byte memory request path.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    typedef struct packed {
        logic                  par_err;
        logic [DEF_DATA_W-1:0] data;
    } rsp_entry_t;

    // Even parity: the stored parity bit equals the XOR of the data byte.
    function automatic logic parity(input logic [DEF_DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_rsp_fifo
// Description : Show-ahead response FIFO; simultaneous push and pop legal.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rsp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = rsp_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  ENTRY_T                 din,
    output ENTRY_T                 dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

    ENTRY_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_do_pop;

    assign w_do_pop = pop && (r_count != '0);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign dout     = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)     r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (r_count == c_FULL) && !w_do_pop));

endmodule
`default_nettype wire

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_ctrl
// Description : Request controller for the parity-protected byte memory.
//               Define MEM_PAR_ERR_CNT_EN to build the parity error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W:0]   mem_data_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_par_err,
    output logic [15:0]       err_cnt
);

    localparam logic [1:0] c_ST_IDLE = ST_IDLE;
    localparam logic [1:0] c_ST_WR   = ST_WR;
    localparam logic [1:0] c_ST_RD   = ST_RD;
    localparam logic [1:0] c_ST_WAIT = ST_WAIT;

    localparam int c_CNT_W  = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int c_FCNT_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(RD_LAT);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(1);
    localparam logic [c_FCNT_W-1:0] c_DEPTH    = c_FCNT_W'(RSP_DEPTH);

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_accept;
    logic                w_push;
    logic                w_empty;
    logic [c_FCNT_W-1:0] w_count;
    rsp_entry_t          w_entry;
    rsp_entry_t          w_head;

    // Requests are only taken in IDLE, so no read is outstanding here and the
    // pre-pop FIFO count alone is a sufficient credit check.
    assign req_ready = rst_n && (r_state == c_ST_IDLE) && (w_count < c_DEPTH);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = (r_state == c_ST_WAIT) && (r_cnt == c_CNT_LAST);

    assign w_entry.data    = mem_data_out[DATA_W-1:0];
    assign w_entry.par_err = parity(mem_data_out[DATA_W-1:0]) != mem_data_out[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_mem_write <= req_write;
                        r_mem_read  <= !req_write;
                        r_state     <= req_write ? c_ST_WR : c_ST_RD;
                    end
                end
                c_ST_WR: r_state <= c_ST_IDLE;
                c_ST_RD: begin
                    r_cnt   <= c_CNT_LOAD;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - c_CNT_LAST;
                    if (r_cnt == c_CNT_LAST) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;

    mem_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .ENTRY_T (rsp_entry_t)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (rsp_ready),
        .din   (w_entry),
        .dout  (w_head),
        .empty (w_empty),
        .count (w_count)
    );

    assign rsp_valid   = !w_empty;
    assign rsp_data    = w_head.data;
    assign rsp_par_err = w_head.par_err;

`ifdef MEM_PAR_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 16'd0;
        end else if (w_push && w_entry.par_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'd0;
`endif

    a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));

endmodule
`default_nettype wire
